ones_window_accum: RTL

- Downstream consumer of the 16-bit ones-count stage.
- Accepts one 5-bit per-word ones count per valid/ready handshake and accumulates counts over a window of WIN_LEN words.
- Emits the window total, the word count and a threshold flag on an output valid/ready handshake.
- Feeds link-density monitoring and bias-detection logic.

---
 rtl/ones_acc_pkg.sv | 29 ++
 rtl/ones_acc_core.sv | 83 ++++++++
 rtl/ones_window_accum.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ones_acc_pkg.sv
// Shared types, constants and helpers for the ones-count window accumulator.
// Optional feature macro: ONES_ACC_PEAK_EN (adds the out_peak port and its tracking logic).
package ones_acc_pkg;

    // The top FSM waits in ACCUM while a window fills, then sits in HOLD until the consumer takes the result.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Width of a per-word ones count. It is tied to the 16-bit popcount stage upstream.
    localparam int ONES_CNT_W    = 5;
    // The largest count a 16-bit word can legally produce.
    localparam int MAX_WORD_ONES = 16;

    // A count above 16 cannot come from a 16-bit word, so it is pinned to 16.
    function automatic logic [ONES_CNT_W-1:0] clamp_count(input logic [ONES_CNT_W-1:0] cnt);
        if (cnt > ONES_CNT_W'(MAX_WORD_ONES)) begin
            return ONES_CNT_W'(MAX_WORD_ONES);
        end
        return cnt;
    endfunction

    // Returns 1 for a count that the upstream stage could never produce.
    function automatic logic count_illegal(input logic [ONES_CNT_W-1:0] cnt);
        return (cnt > ONES_CNT_W'(MAX_WORD_ONES));
    endfunction

endpackage

// File: rtl/ones_acc_core.sv
// Window datapath: running sum, word counter, illegal-count flag and (optionally) peak count.
// The *_nxt outputs already include a word accepted this cycle, so the top can close the
// window on the same edge that takes in the last word.
// Optional feature macro: ONES_ACC_PEAK_EN (adds peak_nxt and its register).
module ones_acc_core
    import ones_acc_pkg::*;
#(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = ONES_CNT_W,
    parameter int SUM_W   = CNT_W + $clog2(WIN_LEN),
    parameter int WORDS_W = $clog2(WIN_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               add_en,
    input  logic [CNT_W-1:0]   in_count,
    input  logic               clear,
    output logic [SUM_W-1:0]   acc_nxt,
    output logic [WORDS_W-1:0] words_nxt,
    output logic               err_nxt
`ifdef ONES_ACC_PEAK_EN
    ,
    output logic [CNT_W-1:0]   peak_nxt
`endif
);

    logic [SUM_W-1:0]   acc_q,   acc_d;
    logic [WORDS_W-1:0] words_q, words_d;
    logic               err_q,   err_d;
    logic [CNT_W-1:0]   cnt_clamped;
`ifdef ONES_ACC_PEAK_EN
    logic [CNT_W-1:0]   peak_q,  peak_d;
`endif

    // Fold an accepted word into the window totals, then apply the close-time clear.
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        cnt_clamped = clamp_count(in_count);
        acc_nxt     = acc_q;
        words_nxt   = words_q;
        err_nxt     = err_q;
`ifdef ONES_ACC_PEAK_EN
        peak_nxt    = peak_q;
`endif
        if (add_en) begin
            acc_nxt   = acc_q + SUM_W'(cnt_clamped);
            words_nxt = words_q + WORDS_W'(1);
            err_nxt   = err_q | count_illegal(in_count);
`ifdef ONES_ACC_PEAK_EN
            if (cnt_clamped > peak_q) begin
                peak_nxt = cnt_clamped;
            end
`endif
        end
        acc_d   = clear ? '0 : acc_nxt;
        words_d = clear ? '0 : words_nxt;
        err_d   = clear ? 1'b0 : err_nxt;
`ifdef ONES_ACC_PEAK_EN
        peak_d  = clear ? '0 : peak_nxt;
`endif
    end

    // Window state registers; an asynchronous reset discards any partial window.
    // NOTE: state registers use non-blocking assignments so every flop samples values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
`ifdef ONES_ACC_PEAK_EN
            peak_q  <= '0;
`endif
        end else begin
            acc_q   <= acc_d;
            words_q <= words_d;
            err_q   <= err_d;
`ifdef ONES_ACC_PEAK_EN
            peak_q  <= peak_d;
`endif
        end
    end

endmodule

// File: rtl/ones_window_accum.sv
// Accumulates per-word ones counts over windows of WIN_LEN words (or shorter on flush) and
// presents the window sum, word count, threshold flag and error flag on a valid/ready port.
// Optional feature macro: ONES_ACC_PEAK_EN (adds out_peak, the largest clamped count in the window).
module ones_window_accum
    import ones_acc_pkg::*;
#(
    parameter int WIN_LEN = 16,
    parameter int THRESH  = 128,
    parameter int CNT_W   = ONES_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CNT_W-1:0]             in_count,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CNT_W+$clog2(WIN_LEN)-1:0] out_sum,
    output logic [$clog2(WIN_LEN):0]     out_words,
    output logic                         out_over,
    output logic                         out_err
`ifdef ONES_ACC_PEAK_EN
    ,
    output logic [CNT_W-1:0]             out_peak
`endif
);

    // The sum width is derived so that 16*WIN_LEN always fits; it is not meant to be overridden.
    localparam int SUM_W   = CNT_W + $clog2(WIN_LEN);
    localparam int WORDS_W = $clog2(WIN_LEN) + 1;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [SUM_W-1:0]   out_sum_q,   out_sum_d;
    logic [WORDS_W-1:0] out_words_q, out_words_d;
    logic               out_over_q,  out_over_d;
    logic               out_err_q,   out_err_d;
`ifdef ONES_ACC_PEAK_EN
    logic [CNT_W-1:0]   out_peak_q,  out_peak_d;
    logic [CNT_W-1:0]   peak_nxt;
`endif

    logic               accept;
    logic               close;
    logic [SUM_W-1:0]   acc_nxt;
    logic [WORDS_W-1:0] words_nxt;
    logic               err_nxt;

    ones_acc_core #(
        .WIN_LEN (WIN_LEN),
        .CNT_W   (CNT_W),
        .SUM_W   (SUM_W),
        .WORDS_W (WORDS_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .add_en    (accept),
        .in_count  (in_count),
        .clear     (close),
        .acc_nxt   (acc_nxt),
        .words_nxt (words_nxt),
        .err_nxt   (err_nxt)
`ifdef ONES_ACC_PEAK_EN
        ,
        .peak_nxt  (peak_nxt)
`endif
    );

    // Next state and output-register capture: close on the last word or a non-empty flush, release on handshake.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_words_d = out_words_q;
        out_over_d  = out_over_q;
        out_err_d   = out_err_q;
`ifdef ONES_ACC_PEAK_EN
        out_peak_d  = out_peak_q;
`endif
        in_ready    = (state_q == ACCUM);
        accept      = in_valid & in_ready;
        // words_nxt counts a word taken this cycle, so a flush with that word closes, and an empty flush does not.
        close       = (state_q == ACCUM) &&
                      ((accept && (words_nxt == WORDS_W'(WIN_LEN))) ||
                       (flush && (words_nxt != '0)));
        case (state_q)
            ACCUM: begin
                if (close) begin
                    state_d     = HOLD;
                    out_valid_d = 1'b1;
                    out_sum_d   = acc_nxt;
                    out_words_d = words_nxt;
                    out_over_d  = (32'(acc_nxt) >= 32'(THRESH));
                    out_err_d   = err_nxt;
`ifdef ONES_ACC_PEAK_EN
                    out_peak_d  = peak_nxt;
`endif
                end
            end
            HOLD: begin
                // Result data stays on the port after the handshake; only valid drops.
                if (out_ready) begin
                    state_d     = ACCUM;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_words_q <= '0;
            out_over_q  <= 1'b0;
            out_err_q   <= 1'b0;
`ifdef ONES_ACC_PEAK_EN
            out_peak_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_words_q <= out_words_d;
            out_over_q  <= out_over_d;
            out_err_q   <= out_err_d;
`ifdef ONES_ACC_PEAK_EN
            out_peak_q  <= out_peak_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_words = out_words_q;
    assign out_over  = out_over_q;
    assign out_err   = out_err_q;
`ifdef ONES_ACC_PEAK_EN
    assign out_peak  = out_peak_q;
`endif

endmodule
